// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU run-control sequencer: run states, command
// opcodes and the cause reported with each done pulse.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_STEP   = 2'b10,
        ST_HALTED = 2'b11
    } run_state_e;

    typedef enum logic [1:0] {
        OP_STOP    = 2'b00,
        OP_RUN     = 2'b01,
        OP_STEP    = 2'b10,
        OP_RESTART = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        CAUSE_STOP  = 2'b00,
        CAUSE_BREAK = 2'b01,
        CAUSE_HALT  = 2'b10,
        CAUSE_STEP  = 2'b11
    } done_cause_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value; a synchronous clear takes
// priority over the increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = '1;
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/cpu_exec_ctrl.sv
// Run-control sequencer for the 4-bit CPU: gates the core clock enable, issues
// core reset pulses and reports why execution stopped.
module cpu_exec_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int PC_W  = 4,
    parameter int CYC_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  cpu_pc,
    input  logic             cpu_halt,
    output logic             cpu_en,
    output logic             cpu_rst,
    output logic [1:0]       run_state,
    output logic             done,
    output logic [1:0]       done_cause,
    output logic [CYC_W-1:0] cycle_cnt
);

    // Handshake: a command transfers on a rising edge where cmd_valid and
    // cmd_ready are both 1; the host holds cmd_op stable while cmd_valid is high.
    run_state_e  state_q, state_d;
    done_cause_e cause_d;
    logic        done_d, rst_d, first_q, first_d;
    logic        accept, restart, bp_hit;
    cmd_op_e     op;

    assign op        = cmd_op_e'(cmd_op);
    assign cmd_ready = (state_q != ST_STEP);
    assign accept    = cmd_valid && cmd_ready;
    assign restart   = accept && (op == OP_RESTART);
    // The first RUN cycle ignores the breakpoint so execution can resume from it.
    assign bp_hit    = bp_en && (cpu_pc == bp_addr) && !first_q;
    assign run_state = state_q;

    always_comb begin
        state_d = state_q;
        cause_d = done_cause_e'(done_cause);
        done_d  = 1'b0;
        rst_d   = 1'b0;
        first_d = 1'b0;
        cpu_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && (op == OP_RUN)) begin
                    state_d = ST_RUN;
                    first_d = 1'b1;
                end else if (accept && (op == OP_STEP)) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                if (cpu_halt) begin
                    state_d = ST_HALTED;
                    done_d  = 1'b1;
                    cause_d = CAUSE_HALT;
                end else if (bp_hit) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    cause_d = CAUSE_BREAK;
                end else begin
                    cpu_en = 1'b1;
                    if (accept && (op == OP_STOP)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        cause_d = CAUSE_STOP;
                    end
                end
            end
            ST_STEP: begin
                done_d = 1'b1;
                if (cpu_halt) begin
                    state_d = ST_HALTED;
                    cause_d = CAUSE_HALT;
                end else begin
                    cpu_en  = 1'b1;
                    state_d = ST_IDLE;
                    cause_d = CAUSE_STEP;
                end
            end
            default: ;
        endcase
        // RESTART overrides everything else and never reports a done.
        if (restart) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
            cause_d = done_cause_e'(done_cause);
            rst_d   = 1'b1;
            first_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            first_q    <= 1'b0;
            cpu_rst    <= 1'b1;
            done       <= 1'b0;
            done_cause <= 2'b00;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            cpu_rst <= rst_d;
            done    <= done_d;
            if (done_d) begin
                done_cause <= cause_d;
            end
        end
    end

    sat_counter #(.W(CYC_W)) u_cycle_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (cpu_en),
        .clr     (restart),
        .count   (cycle_cnt)
    );

endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// Directed bench for cpu_exec_ctrl with a small core model (PC counter that
// halts at a chosen address) and a queue of expected done causes.
module tb_cpu_exec_ctrl;

    localparam int PC_W  = 4;
    localparam int CYC_W = 4;

    localparam logic [1:0] OP_STOP = 2'b00, OP_RUN = 2'b01, OP_STEP = 2'b10, OP_RESTART = 2'b11;
    localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_STEP = 2'b10, S_HALTED = 2'b11;
    localparam logic [1:0] C_STOP = 2'b00, C_BREAK = 2'b01, C_HALT = 2'b10, C_STEP = 2'b11;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             cmd_valid, cmd_ready;
    logic [1:0]       cmd_op;
    logic             bp_en;
    logic [PC_W-1:0]  bp_addr;
    logic [PC_W-1:0]  cpu_pc;
    logic             cpu_halt;
    logic             cpu_en, cpu_rst, done;
    logic [1:0]       run_state, done_cause;
    logic [CYC_W-1:0] cycle_cnt;

    logic             halt_en;
    logic [PC_W-1:0]  halt_pc;
    logic [1:0]       exp_q[$];
    int               n_checks = 0;
    int               n_fail = 0;

    cpu_exec_ctrl #(.PC_W(PC_W), .CYC_W(CYC_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .cpu_pc     (cpu_pc),
        .cpu_halt   (cpu_halt),
        .cpu_en     (cpu_en),
        .cpu_rst    (cpu_rst),
        .run_state  (run_state),
        .done       (done),
        .done_cause (done_cause),
        .cycle_cnt  (cycle_cnt)
    );

    // Clock/reset and core model
    always #5 clk = ~clk;

    assign cpu_halt = halt_en && (cpu_pc == halt_pc);

    always @(posedge clk) begin
        if (!reset_n || cpu_rst) cpu_pc <= '0;
        else if (cpu_en)         cpu_pc <= cpu_pc + 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest expected cause
    always @(negedge clk) begin
        if (reset_n === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                check("done_cause", {30'd0, done_cause}, {30'd0, exp_q.pop_front()});
            end
        end
    end

    // Driver
    task automatic send_cmd(input logic [1:0] op);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_pc(input logic [PC_W-1:0] pc, input string tag);
        int n;
        n = 0;
        while (cpu_pc !== pc && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, (n < 100)}, 32'd1);
    endtask

    initial begin
        reset_n   = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_STOP;
        bp_en     = 1'b0;
        bp_addr   = '0;
        halt_en   = 1'b0;
        halt_pc   = '0;
        #1 reset_n = 1'b0;
        #1;
        check("rst_state",  {30'd0, run_state}, {30'd0, S_IDLE});
        check("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("rst_cnt",    {28'd0, cycle_cnt}, 32'd0);
        check("rst_done",   {31'd0, done}, 32'd0);
        check("rst_ready",  {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_pulse_end", {31'd0, cpu_rst}, 32'd0);

        // 1: async reset in the middle of RUN
        send_cmd(OP_RUN);
        check("t1_run", {30'd0, run_state}, {30'd0, S_RUN});
        repeat (3) @(negedge clk);
        check("t1_cnt3", {28'd0, cycle_cnt}, 32'd3);
        #1 reset_n = 1'b0;
        #1;
        check("t1_state", {30'd0, run_state}, {30'd0, S_IDLE});
        check("t1_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("t1_cnt", {28'd0, cycle_cnt}, 32'd0);
        check("t1_done", {31'd0, done}, 32'd0);
        check("t1_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // 2: RUN until HALT at pc 5
        halt_en = 1'b1;
        halt_pc = 4'd5;
        exp_q.push_back(C_HALT);
        send_cmd(OP_RUN);
        wait_pc(4'd5, "t2_reach_pc5");
        check("t2_cpu_en_halt", {31'd0, cpu_en}, 32'd0);
        @(negedge clk);
        check("t2_state", {30'd0, run_state}, {30'd0, S_HALTED});
        check("t2_done", {31'd0, done}, 32'd1);
        check("t2_cnt", {28'd0, cycle_cnt}, 32'd5);
        send_cmd(OP_STEP);
        check("t2_step_noop", {30'd0, run_state}, {30'd0, S_HALTED});
        check("t2_halt_en_low", {31'd0, cpu_en}, 32'd0);
        send_cmd(OP_RESTART);
        halt_en = 1'b0;
        check("t2_restart_state", {30'd0, run_state}, {30'd0, S_IDLE});
        check("t2_restart_rst", {31'd0, cpu_rst}, 32'd1);
        check("t2_restart_cnt", {28'd0, cycle_cnt}, 32'd0);
        @(negedge clk);
        check("t2_pc_reset", {28'd0, cpu_pc}, 32'd0);

        // 3: breakpoint at pc 3, resume past it, then STOP
        bp_en   = 1'b1;
        bp_addr = 4'd3;
        exp_q.push_back(C_BREAK);
        send_cmd(OP_RUN);
        wait_pc(4'd3, "t3_reach_pc3");
        check("t3_cpu_en_bp", {31'd0, cpu_en}, 32'd0);
        @(negedge clk);
        check("t3_state", {30'd0, run_state}, {30'd0, S_IDLE});
        check("t3_pc_held", {28'd0, cpu_pc}, 32'd3);
        check("t3_cnt", {28'd0, cycle_cnt}, 32'd3);
        send_cmd(OP_RUN);
        check("t3_resume_en", {31'd0, cpu_en}, 32'd1);
        check("t3_resume_pc", {28'd0, cpu_pc}, 32'd3);
        exp_q.push_back(C_STOP);
        send_cmd(OP_STOP);
        check("t3_stop_state", {30'd0, run_state}, {30'd0, S_IDLE});
        check("t3_stop_pc", {28'd0, cpu_pc}, 32'd5);
        check("t3_stop_cnt", {28'd0, cycle_cnt}, 32'd5);
        bp_en = 1'b0;

        // 4: three single steps from pc 0
        send_cmd(OP_RESTART);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(C_STEP);
            send_cmd(OP_STEP);
            check("t4_state_step", {30'd0, run_state}, {30'd0, S_STEP});
            check("t4_ready_low", {31'd0, cmd_ready}, 32'd0);
            check("t4_cpu_en", {31'd0, cpu_en}, 32'd1);
            @(negedge clk);
            check("t4_state_idle", {30'd0, run_state}, {30'd0, S_IDLE});
            check("t4_pc", {28'd0, cpu_pc}, i + 1);
            check("t4_en_idle", {31'd0, cpu_en}, 32'd0);
        end
        check("t4_cnt", {28'd0, cycle_cnt}, 32'd3);

        // 5: RESTART in the same cycle as HALT wins
        send_cmd(OP_RESTART);
        @(negedge clk);
        halt_en = 1'b1;
        halt_pc = 4'd2;
        send_cmd(OP_RUN);
        wait_pc(4'd2, "t5_reach_pc2");
        check("t5_halt_seen", {31'd0, cpu_halt}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = OP_RESTART;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("t5_state", {30'd0, run_state}, {30'd0, S_IDLE});
        check("t5_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("t5_cnt", {28'd0, cycle_cnt}, 32'd0);
        check("t5_no_done", {31'd0, done}, 32'd0);
        halt_en = 1'b0;
        @(negedge clk);

        // 6: counter saturation, then STOP
        send_cmd(OP_RUN);
        repeat (20) @(negedge clk);
        check("t6_state", {30'd0, run_state}, {30'd0, S_RUN});
        check("t6_sat", {28'd0, cycle_cnt}, 32'd15);
        exp_q.push_back(C_STOP);
        send_cmd(OP_STOP);
        check("t6_stop_state", {30'd0, run_state}, {30'd0, S_IDLE});
        check("t6_sat_hold", {28'd0, cycle_cnt}, 32'd15);
        check("t6_cause_held", {30'd0, done_cause}, {30'd0, C_STOP});
        repeat (2) @(negedge clk);

        check("exp_q_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
